window_scanner: RTL

- Parametrised successor to the single-shot window reader.
- On one start pulse it raster-scans a full IMG_HEIGHT x IMG_WIDTH image held in the shared Memory block and visits every window centre on a STRIDE grid.
- For each centre it fetches a WINDOW x WINDOW neighbourhood over the Memory rw/addr/drdy handshake, handles image borders in the selected padding mode, and presents each packed window on a valid/ready output.

---
 rtl/window_scanner_pkg.sv | 21 ++
 rtl/window_scanner_addr_gen.sv | 47 ++++
 rtl/window_scanner.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/window_scanner_pkg.sv
// Shared types and constants for the window scanner and its address generator.
package window_scanner_pkg;

  localparam logic [1:0] RW_IDLE = 2'b00;
  localparam logic [1:0] RW_READ = 2'b01;

  localparam logic PAD_ZERO = 1'b0;
  localparam logic PAD_REPL = 1'b1;

  // Element index width; WINDOW never exceeds 7.
  localparam int IDX_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

endpackage

// File: rtl/window_scanner_addr_gen.sv
// Combinational map from window centre and element index to a memory address,
// flagging elements that fall outside the image in zero-fill mode.
module window_addr_gen
  import window_scanner_pkg::*;
#(
  parameter int BUS_WIDTH  = 8,
  parameter int IMG_WIDTH  = 7,
  parameter int IMG_HEIGHT = 7,
  parameter int WINDOW     = 3
) (
  input  logic [BUS_WIDTH-1:0] i_row,
  input  logic [BUS_WIDTH-1:0] i_col,
  input  logic [IDX_W-1:0]     i_ei,
  input  logic [IDX_W-1:0]     i_ej,
  input  logic                 i_pad_mode,
  output logic [BUS_WIDTH-1:0] o_addr,
  output logic                 o_is_pad
);

  localparam int SW = BUS_WIDTH + 1;
  localparam logic signed [SW-1:0]      HALF  = SW'(WINDOW / 2);
  localparam logic signed [SW-1:0]      MAX_R = SW'(IMG_HEIGHT - 1);
  localparam logic signed [SW-1:0]      MAX_C = SW'(IMG_WIDTH - 1);
  localparam logic [2*BUS_WIDTH-1:0]    IW    = (2*BUS_WIDTH)'(IMG_WIDTH);

  logic signed [SW-1:0] w_rr;
  logic signed [SW-1:0] w_cc;
  logic signed [SW-1:0] w_rr_cl;
  logic signed [SW-1:0] w_cc_cl;
  logic                 w_oob;

  always_comb begin
    w_rr = $signed({1'b0, i_row}) + $signed(SW'(i_ei)) - HALF;
    w_cc = $signed({1'b0, i_col}) + $signed(SW'(i_ej)) - HALF;
    w_oob = w_rr[SW-1] || (w_rr > MAX_R) || w_cc[SW-1] || (w_cc > MAX_C);

    // Clamped coordinates drive the address in both modes; in zero mode an
    // out-of-range element never reaches memory, so the clamp is harmless.
    w_rr_cl = w_rr[SW-1] ? '0 : ((w_rr > MAX_R) ? MAX_R : w_rr);
    w_cc_cl = w_cc[SW-1] ? '0 : ((w_cc > MAX_C) ? MAX_C : w_cc);

    o_is_pad = w_oob && (i_pad_mode == PAD_ZERO);
    o_addr   = BUS_WIDTH'((2*BUS_WIDTH)'($unsigned(BUS_WIDTH'(w_rr_cl))) * IW
                        + (2*BUS_WIDTH)'($unsigned(BUS_WIDTH'(w_cc_cl))));
  end

endmodule

// File: rtl/window_scanner.sv
// Raster-scans an image in Memory and presents each WINDOW x WINDOW neighbourhood.
// Optional win_sum output enabled by defining WINDOW_SCANNER_SUM_EN.
module window_scanner
  import window_scanner_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int BUS_WIDTH  = 8,
  parameter int IMG_WIDTH  = 7,
  parameter int IMG_HEIGHT = 7,
  parameter int WINDOW     = 3,
  parameter int STRIDE     = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                pad_mode,
  input  logic [DATA_WIDTH-1:0]               mem_data,
  input  logic                                mem_drdy,
  output logic [BUS_WIDTH-1:0]                mem_addr,
  output logic [1:0]                          mem_rw,
  output logic [DATA_WIDTH*WINDOW*WINDOW-1:0] win_data,
  output logic                                win_valid,
  input  logic                                win_ready,
  output logic [BUS_WIDTH-1:0]                win_row,
  output logic [BUS_WIDTH-1:0]                win_col,
`ifdef WINDOW_SCANNER_SUM_EN
  output logic [DATA_WIDTH+$clog2(WINDOW*WINDOW)-1:0] win_sum,
`endif
  output logic                                busy,
  output logic                                done
);

  if (IMG_WIDTH * IMG_HEIGHT > 2**BUS_WIDTH) begin : g_err_size
    $error("window_scanner: image does not fit the address bus");
  end
  if (WINDOW % 2 == 0) begin : g_err_window
    $error("window_scanner: WINDOW must be odd");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WINDOW - 1);

  state_t                          r_state;
  state_t                          w_next;
  logic [BUS_WIDTH-1:0]            r_row;
  logic [BUS_WIDTH-1:0]            r_col;
  logic [IDX_W-1:0]                r_ei;
  logic [IDX_W-1:0]                r_ej;
  logic                            r_pad;
  logic [BUS_WIDTH-1:0]            r_addr;
  logic [1:0]                      r_rw;
  logic [DATA_WIDTH*WINDOW*WINDOW-1:0] r_win;
  logic [BUS_WIDTH-1:0]            w_addr;
  logic                            w_is_pad;
  logic                            w_last;
  logic                            w_we;
  logic [DATA_WIDTH-1:0]           w_wval;
  logic [5:0]                      w_slot;
  logic [BUS_WIDTH:0]              w_col_nx;
  logic [BUS_WIDTH:0]              w_row_nx;
  logic                            w_col_wrap;
  logic                            w_scan_end;

  window_addr_gen #(
    .BUS_WIDTH (BUS_WIDTH),
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .WINDOW    (WINDOW)
  ) u_addr_gen (
    .i_row     (r_row),
    .i_col     (r_col),
    .i_ei      (r_ei),
    .i_ej      (r_ej),
    .i_pad_mode(r_pad),
    .o_addr    (w_addr),
    .o_is_pad  (w_is_pad)
  );

  assign w_last     = (r_ei == LAST_IDX) && (r_ej == LAST_IDX);
  assign w_slot     = 6'(r_ei) * 6'(WINDOW) + 6'(r_ej);
  assign w_we       = ((r_state == S_ISSUE) && w_is_pad) || ((r_state == S_WAIT) && mem_drdy);
  assign w_wval     = (r_state == S_WAIT) ? mem_data : '0;
  assign w_col_nx   = {1'b0, r_col} + (BUS_WIDTH+1)'(STRIDE);
  assign w_row_nx   = {1'b0, r_row} + (BUS_WIDTH+1)'(STRIDE);
  assign w_col_wrap = w_col_nx >= (BUS_WIDTH+1)'(IMG_WIDTH);
  assign w_scan_end = w_col_wrap && (w_row_nx >= (BUS_WIDTH+1)'(IMG_HEIGHT));

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    done      = 1'b0;
    win_valid = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_ISSUE;
      S_ISSUE: begin
        busy = 1'b1;
        if (!w_is_pad)  w_next = S_WAIT;
        else if (w_last) w_next = S_PRESENT;
      end
      S_WAIT: begin
        busy = 1'b1;
        if (mem_drdy) w_next = w_last ? S_PRESENT : S_ISSUE;
      end
      S_PRESENT: begin
        busy      = 1'b1;
        win_valid = 1'b1;
        if (win_ready) w_next = w_scan_end ? S_DONE : S_ISSUE;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_ei   <= '0;
      r_ej   <= '0;
      r_pad  <= PAD_ZERO;
      r_addr <= '0;
      r_rw   <= RW_IDLE;
      r_win  <= '0;
    end else begin
      if ((r_state == S_IDLE) && start) begin
        r_pad <= pad_mode;
        r_row <= '0;
        r_col <= '0;
        r_ei  <= '0;
        r_ej  <= '0;
      end
      if ((r_state == S_ISSUE) && !w_is_pad) begin
        r_addr <= w_addr;
        r_rw   <= RW_READ;
      end
      if ((r_state == S_WAIT) && mem_drdy) r_rw <= RW_IDLE;
      if (w_we) begin
        r_win[w_slot*DATA_WIDTH +: DATA_WIDTH] <= w_wval;
        // Column index advances first; the last element wraps both to 0.
        if (r_ej == LAST_IDX) begin
          r_ej <= '0;
          r_ei <= w_last ? '0 : r_ei + IDX_W'(1);
        end else begin
          r_ej <= r_ej + IDX_W'(1);
        end
      end
      if ((r_state == S_PRESENT) && win_ready) begin
        if (w_scan_end) begin
          r_row <= '0;
          r_col <= '0;
        end else if (w_col_wrap) begin
          r_col <= '0;
          r_row <= w_row_nx[BUS_WIDTH-1:0];
        end else begin
          r_col <= w_col_nx[BUS_WIDTH-1:0];
        end
      end
    end
  end

`ifdef WINDOW_SCANNER_SUM_EN
  localparam int SUM_W = DATA_WIDTH + $clog2(WINDOW*WINDOW);
  logic [SUM_W-1:0] r_sum;

  // The first element of each window restarts the running sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_sum <= '0;
    else if (w_we) r_sum <= ((r_ei == '0) && (r_ej == '0)) ? SUM_W'(w_wval)
                                                           : r_sum + SUM_W'(w_wval);
  end

  assign win_sum = r_sum;
`endif

  assign mem_addr = r_addr;
  assign mem_rw   = r_rw;
  assign win_data = r_win;
  assign win_row  = r_row;
  assign win_col  = r_col;

endmodule
